apb_arbiter2: RTL and testbench
===============================

Name: apb_arbiter2

Overview:
- Two-master to one-slave APB arbiter placed upstream of the APB delayer/peripheral crossbar.
- Lets two APB initiators share one APB target port, with round-robin grant per transaction.
- Each granted request is captured, replayed downstream as a clean SETUP/ACCESS sequence, and answered with a one-cycle registered pready.
- A per-transaction timeout terminates hung accesses with pslverr.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (strobe width = DATA_W/8)
TIMEOUT, 1024, max ACCESS cycles before forced error completion; 0 disables the timeout
CNT_W, 16, timeout counter width; TIMEOUT must be < 2^CNT_W

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
mN_paddr  in  ADDR_W  master N address (N = 0, 1, for all mN_ ports)
mN_psel  in  1  master N select
mN_penable  in  1  master N enable (ignored; see Behaviour)
mN_pprot  in  3  master N protection
mN_pwrite  in  1  master N write
mN_pwdata  in  DATA_W  master N write data
mN_pstrb  in  DATA_W/8  master N strobes
mN_pready  out  1  master N completion pulse
mN_prdata  out  DATA_W  master N read data
mN_pslverr  out  1  master N error
out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb  out  (APB widths)  downstream request
out_pready, out_prdata, out_pslverr  in  (APB widths)  downstream response

Behaviour:
- Reset: asynchronous on reset_n low.
  - All outputs 0, state IDLE, timeout count 0.
  - last_grant = 1, so m0 wins the first tie.
  - Reset mid-transaction abandons it; no pready is issued.
- All outputs are registered.
- States IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any mN_psel = 1, pick a winner. With only one requester, it wins. With both, the master != last_grant wins.
  - Capture the winner's paddr/pprot/pwrite/pwdata/pstrb into the request register, record grant and last_grant, then go to SETUP.
- SETUP: out_psel = 1, out_penable = 0, out_* = captured fields, count cleared. Next state ACCESS.
- ACCESS:
  - out_psel = 1, out_penable = 1.
  - If out_pready = 1: capture out_prdata and out_pslverr, go to RESP.
  - Else if TIMEOUT != 0 and count == TIMEOUT-1: capture prdata = 0, pslverr = 1, go to RESP.
  - Else increment count (saturating at TIMEOUT-1) and stay.
- RESP:
  - out_psel = 0, out_penable = 0.
  - Granted mN_pready = 1 for exactly one cycle, with mN_prdata and mN_pslverr valid that cycle.
  - The other master's pready stays 0.
  - Next state IDLE; mN_prdata and mN_pslverr return to 0 in IDLE.
- Latency: psel first high in cycle 0 → SETUP in cycle 1 → ACCESS in cycle 2 → earliest mN_pready in cycle 3. Each downstream wait cycle adds 1.
- Grant is transaction-atomic. A request arriving mid-transaction waits, and its psel must be held until pready.
- mN_penable is not checked; capture happens on psel alone.
- A master dropping psel mid-transaction does not abort the transaction. The downstream access completes and the pready pulse is still issued.
- Back-to-back: a master may re-assert psel in the IDLE cycle after its RESP. If the other master is also waiting, round-robin gives the other master the grant.
- A downstream response with pready high in SETUP is ignored; only ACCESS samples out_pready.

Decomposition:
- Package apb_arb_pkg:
  - arb_state_t enum {IDLE, SETUP, ACCESS, RESP}
  - struct apb_req_t {paddr, pprot, pwrite, pwdata, pstrb}
  - localparam NUM_MASTERS = 2
- Sub-module apb_arb_rr: combinational 2-way round-robin pick from {req0, req1, last_grant} → {gnt_valid, gnt_idx}.
- Top module holds the FSM, request register, timeout counter and response registers.

Test Plan:
- Single read: m0 reads 0x1000_0000; slave returns pready in first ACCESS with prdata 0xDEADBEEF → m0_pready high in cycle 3, prdata 0xDEADBEEF, pslverr 0; m1_pready never high.
- Wait states: m1 writes 0x2000_0004, data 0x12345678, pstrb 0xF; slave holds pready low for 5 ACCESS cycles → out fields stable throughout; m1_pready in cycle 8.
- Contention: both psel high in the same cycle after reset → m0 served first, then m1; repeat with both high → m0 served again. Grant order over 4 transactions: 0, 1, 0, 1.
- Timeout: TIMEOUT = 8, slave never asserts pready → exactly 8 ACCESS cycles, then mN_pready = 1, pslverr = 1, prdata = 0; arbiter back in IDLE.
- Reset mid-ACCESS: reset_n low during cycle 2 → all outputs 0 asynchronously, no pready; after release, a new m1 request completes normally with m0 tie priority restored.
- Slave error: out_pslverr = 1 with pready → granted master sees pslverr = 1 for exactly one cycle, 0 next cycle.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types for the two-master APB arbiter.
// Request bundle widths match the default APB address/data widths.
package apb_arb_pkg;

   localparam int NUM_MASTERS = 2;
   localparam int REQ_AW      = 32;
   localparam int REQ_DW      = 32;
   localparam int REQ_SW      = REQ_DW / 8;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } arb_state_t;

   typedef struct packed {
      logic [REQ_AW-1:0] paddr;
      logic [2:0]        pprot;
      logic              pwrite;
      logic [REQ_DW-1:0] pwdata;
      logic [REQ_SW-1:0] pstrb;
   } apb_req_t;

endpackage

// File: rtl/apb_arbiter2_if.sv
// One APB link: request from master to slave, response back.
// Used for both upstream initiators and the downstream target.
interface apb_arbiter2_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic [ADDR_W-1:0]   paddr;
   logic                psel;
   logic                penable;
   logic [2:0]          pprot;
   logic                pwrite;
   logic [DATA_W-1:0]   pwdata;
   logic [DATA_W/8-1:0] pstrb;
   logic                pready;
   logic [DATA_W-1:0]   prdata;
   logic                pslverr;

   modport master (
      output paddr, psel, penable, pprot,
      output pwrite, pwdata, pstrb,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pprot,
      input  pwrite, pwdata, pstrb,
      output pready, prdata, pslverr
   );

endinterface

// File: rtl/apb_arb_rr.sv
// Two-way round-robin pick: on a tie the master that was
// not granted last time wins.
module apb_arb_rr (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic gnt_valid,
   output logic gnt_idx
);

   always_comb begin
      gnt_valid = req0 | req1;
      gnt_idx   = 1'b0;
      unique case (1'b1)
         (req0 && req1):  gnt_idx = ~last_grant;
         (req1 && !req0): gnt_idx = 1'b1;
         default:         gnt_idx = 1'b0;
      endcase
   end

endmodule

// File: rtl/apb_arbiter2.sv
// Two-master to one-slave APB arbiter with registered replay,
// one-cycle pready pulse and per-transaction access timeout.
module apb_arbiter2
   import apb_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 16
) (
   input  logic           clock,
   input  logic           reset_n,
   apb_arbiter2_if.slave  m0,
   apb_arbiter2_if.slave  m1,
   apb_arbiter2_if.master out
);

   localparam bit TO_EN = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TO_LAST =
      TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

   arb_state_t        state_q, state_d;
   apb_req_t          req_q, req_d, req0_w, req1_w;
   logic              gnt_q, gnt_d, last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              psel_q, psel_d, pen_q, pen_d;
   logic [1:0]        rdy_q, rdy_d, err_q, err_d;
   logic [DATA_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
   logic              gnt_valid, gnt_idx;
   logic              fin, fin_err;
   logic [DATA_W-1:0] fin_data;
   logic              unused_penable;

   // penable from the initiators carries no information here
   assign unused_penable = m0.penable ^ m1.penable;

   always_comb begin
      req0_w.paddr  = REQ_AW'(m0.paddr);
      req0_w.pprot  = m0.pprot;
      req0_w.pwrite = m0.pwrite;
      req0_w.pwdata = REQ_DW'(m0.pwdata);
      req0_w.pstrb  = REQ_SW'(m0.pstrb);
      req1_w.paddr  = REQ_AW'(m1.paddr);
      req1_w.pprot  = m1.pprot;
      req1_w.pwrite = m1.pwrite;
      req1_w.pwdata = REQ_DW'(m1.pwdata);
      req1_w.pstrb  = REQ_SW'(m1.pstrb);
   end

   apb_arb_rr u_rr (
      .req0       (m0.psel),
      .req1       (m1.psel),
      .last_grant (last_q),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx)
   );

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      psel_d   = psel_q;
      pen_d    = pen_q;
      rdy_d    = '0;
      err_d    = err_q;
      rd0_d    = rd0_q;
      rd1_d    = rd1_q;
      fin      = 1'b0;
      fin_err  = 1'b0;
      fin_data = '0;
      unique case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               req_d   = gnt_idx ? req1_w : req0_w;
               gnt_d   = gnt_idx;
               last_d  = gnt_idx;
               psel_d  = 1'b1;
               state_d = SETUP;
            end
         end
         SETUP: begin
            pen_d   = 1'b1;
            cnt_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (out.pready) begin
               fin      = 1'b1;
               fin_data = DATA_W'(out.prdata);
               fin_err  = out.pslverr;
            end else if (TO_EN && cnt_q == TO_LAST) begin
               fin     = 1'b1;
               fin_err = 1'b1;
            end else if (TO_EN) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            rd0_d   = '0;
            rd1_d   = '0;
            err_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (fin) begin
         psel_d        = 1'b0;
         pen_d         = 1'b0;
         state_d       = RESP;
         rdy_d[gnt_q]  = 1'b1;
         err_d[gnt_q]  = fin_err;
         if (gnt_q) rd1_d = fin_data;
         else       rd0_d = fin_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         req_q   <= '0;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         psel_q  <= 1'b0;
         pen_q   <= 1'b0;
         rdy_q   <= '0;
         err_q   <= '0;
         rd0_q   <= '0;
         rd1_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         psel_q  <= psel_d;
         pen_q   <= pen_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
         rd0_q   <= rd0_d;
         rd1_q   <= rd1_d;
      end
   end

   assign out.paddr   = ADDR_W'(req_q.paddr);
   assign out.pprot   = req_q.pprot;
   assign out.pwrite  = req_q.pwrite;
   assign out.pwdata  = DATA_W'(req_q.pwdata);
   assign out.pstrb   = (DATA_W/8)'(req_q.pstrb);
   assign out.psel    = psel_q;
   assign out.penable = pen_q;

   assign m0.pready  = rdy_q[0];
   assign m0.prdata  = rd0_q;
   assign m0.pslverr = err_q[0];
   assign m1.pready  = rdy_q[1];
   assign m1.prdata  = rd1_q;
   assign m1.pslverr = err_q[1];

endmodule

// File: tb/tb_apb_arbiter2.sv
// Randomized bench for apb_arbiter2 against a transaction-level
// model of grant order, latency and response content.
module tb_apb_arbiter2;

   localparam int TO = 8;

   logic clock = 1'b0;
   logic reset_n = 1'b0;

   apb_arbiter2_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
   apb_arbiter2_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
   apb_arbiter2_if #(.ADDR_W(32), .DATA_W(32)) out_if ();

   apb_arbiter2 #(.TIMEOUT(TO)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .m0      (m0_if),
      .m1      (m1_if),
      .out     (out_if)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_err = 0;

   // downstream slave: responds after slv_waits wait cycles
   int          slv_waits = 0;
   logic        slv_hang = 0, slv_err = 0, slv_junk = 0;
   logic [31:0] slv_data = 0;
   int          acc_cnt;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) acc_cnt <= 0;
      else if (out_if.psel && out_if.penable) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
   end

   assign out_if.pready =
      (out_if.psel && out_if.penable && !slv_hang && acc_cnt == slv_waits) ||
      (slv_junk && out_if.psel && !out_if.penable);
   assign out_if.prdata  = out_if.pready ? slv_data : 32'h0BAD_0BAD;
   assign out_if.pslverr = out_if.pready & slv_err;

   // per-master pending request and its planned slave behaviour
   logic [31:0] addr[2], wdat[2], rdat[2];
   logic [2:0]  prot[2];
   logic [3:0]  strb[2];
   logic        wr[2], hang[2], err[2], junk[2], pend[2];
   int          waits[2];
   bit          mlast;
   int          reissue_left;

   task automatic chk(input string tag, input logic [95:0] got,
                      input logic [95:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input int i);
      if (i == 0) begin
         m0_if.paddr   = addr[0];
         m0_if.pprot   = prot[0];
         m0_if.pwrite  = wr[0];
         m0_if.pwdata  = wdat[0];
         m0_if.pstrb   = strb[0];
         m0_if.psel    = pend[0];
         m0_if.penable = 1'($urandom_range(0, 1));
      end else begin
         m1_if.paddr   = addr[1];
         m1_if.pprot   = prot[1];
         m1_if.pwrite  = wr[1];
         m1_if.pwdata  = wdat[1];
         m1_if.pstrb   = strb[1];
         m1_if.psel    = pend[1];
         m1_if.penable = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic set_req(input int i, input logic [31:0] a,
                          input logic w, input logic [31:0] d,
                          input logic [3:0] s, input int wt,
                          input logic h, input logic e,
                          input logic [31:0] rd, input logic j);
      addr[i] = a; wr[i] = w; wdat[i] = d; strb[i] = s;
      prot[i] = 3'($urandom_range(0, 7));
      waits[i] = wt; hang[i] = h; err[i] = e;
      rdat[i] = rd; junk[i] = j; pend[i] = 1'b1;
      drive(i);
   endtask

   task automatic rand_req(input int i);
      set_req(i, $urandom, 1'($urandom_range(0, 1)), $urandom,
              4'($urandom_range(0, 15)), $urandom_range(0, 6),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
              $urandom, ($urandom_range(0, 3) == 0));
   endtask

   function automatic logic [71:0] exp_fields(input int w);
      return {addr[w], prot[w], wr[w], wdat[w], strb[w]};
   endfunction

   function automatic logic [71:0] out_fields();
      return {out_if.paddr, out_if.pprot, out_if.pwrite,
              out_if.pwdata, out_if.pstrb};
   endfunction

   function automatic logic [1:0] rdys();
      return {m1_if.pready, m0_if.pready};
   endfunction

   task automatic chk_quiet(input string tag);
      chk({tag, "_bus"}, 96'({out_if.psel, out_if.penable}), 96'(0));
      chk({tag, "_rsp"}, 96'({m1_if.pready, m1_if.prdata, m1_if.pslverr,
                              m0_if.pready, m0_if.prdata, m0_if.pslverr}),
          96'(0));
   endtask

   // Entered at the falling edge of an IDLE cycle with requests set.
   task automatic serve();
      int win, acc;
      logic [31:0] erd;
      logic eerr;
      while (pend[0] || pend[1]) begin
         if (pend[0] && pend[1]) win = mlast ? 0 : 1;
         else win = pend[1] ? 1 : 0;
         mlast = win[0];
         slv_waits = waits[win]; slv_hang = hang[win];
         slv_err = err[win]; slv_data = rdat[win]; slv_junk = junk[win];
         acc = hang[win] ? TO : waits[win] + 1;
         erd = hang[win] ? 32'h0 : rdat[win];
         eerr = hang[win] ? 1'b1 : err[win];
         @(negedge clock);
         chk("setup_bus", 96'({out_if.psel, out_if.penable}), 96'(2'b10));
         chk("setup_fields", 96'(out_fields()), 96'(exp_fields(win)));
         chk("setup_rdy", 96'(rdys()), 96'(0));
         for (int k = 0; k < acc; k++) begin
            @(negedge clock);
            chk("access_bus", 96'({out_if.psel, out_if.penable}), 96'(2'b11));
            chk("access_fields", 96'(out_fields()), 96'(exp_fields(win)));
            chk("access_rdy", 96'(rdys()), 96'(0));
         end
         @(negedge clock);
         chk("resp_rdy", 96'(rdys()), 96'(win == 1 ? 2'b10 : 2'b01));
         chk("resp_rdata", 96'(win == 1 ? m1_if.prdata : m0_if.prdata),
             96'(erd));
         chk("resp_err", 96'(win == 1 ? m1_if.pslverr : m0_if.pslverr),
             96'(eerr));
         chk("resp_bus", 96'({out_if.psel, out_if.penable}), 96'(0));
         pend[win] = 1'b0;
         drive(win);
         if (reissue_left > 0 && $urandom_range(0, 2) == 0) begin
            reissue_left--;
            rand_req(win);
         end
         @(negedge clock);
         chk_quiet("idle");
      end
   endtask

   initial begin
      pend[0] = 0; pend[1] = 0;
      addr[0] = 0; addr[1] = 0; wdat[0] = 0; wdat[1] = 0;
      prot[0] = 0; prot[1] = 0; wr[0] = 0; wr[1] = 0;
      strb[0] = 0; strb[1] = 0;
      drive(0); drive(1);
      mlast = 1'b1;
      reissue_left = 0;
      repeat (3) @(negedge clock);
      chk("rst_fields", 96'(out_fields()), 96'(0));
      chk_quiet("rst");
      reset_n = 1'b1;

      // single read from m0
      set_req(0, 32'h1000_0000, 0, 0, 4'h0, 0, 0, 0, 32'hDEAD_BEEF, 0);
      serve();
      // m1 write with five wait states
      set_req(1, 32'h2000_0004, 1, 32'h1234_5678, 4'hF, 5, 0, 0, 0, 0);
      serve();
      // contention twice: 0,1,0,1
      rand_req(0); rand_req(1); serve();
      rand_req(0); rand_req(1); serve();
      // hung slave reaches timeout
      set_req(0, 32'h3000_0000, 0, 0, 4'h0, 0, 1, 0, 32'h5555_AAAA, 0);
      serve();
      // slave error pulse
      set_req(1, 32'h4000_0008, 1, 32'hCAFE_F00D, 4'h3, 1, 0, 1, 0, 0);
      serve();
      // pready during SETUP must be ignored
      set_req(0, 32'h5000_0000, 0, 0, 4'h0, 2, 0, 0, 32'h0F0F_0F0F, 1);
      serve();

      // reset in the middle of ACCESS
      set_req(0, 32'h6000_0000, 0, 0, 4'h0, 0, 1, 0, 0, 0);
      slv_hang = 1'b1; slv_junk = 1'b0;
      @(negedge clock);
      @(negedge clock);
      chk("pre_rst_bus", 96'({out_if.psel, out_if.penable}), 96'(2'b11));
      #1 reset_n = 1'b0;
      #1;
      chk("async_rst_fields", 96'(out_fields()), 96'(0));
      chk_quiet("async_rst");
      pend[0] = 1'b0; drive(0);
      @(negedge clock);
      chk_quiet("in_rst");
      reset_n = 1'b1;
      mlast = 1'b1;
      @(negedge clock);
      chk_quiet("post_rst");
      rand_req(0); rand_req(1); serve();
      rand_req(1); serve();

      // random traffic
      reissue_left = 15;
      for (int n = 0; n < 40; n++) begin
         int r;
         r = $urandom_range(1, 3);
         if (r[0]) rand_req(0);
         if (r[1]) rand_req(1);
         serve();
         if ($urandom_range(0, 1) == 1) begin
            @(negedge clock);
            chk_quiet("gap");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
